// File: rtl/layer3_neuron_mac.sv
// rtl/layer3_neuron_mac.sv - layer-3 sequential MAC neuron engine with bias, saturation and optional ReLU
module layer3_neuron_mac #(
    parameter int N_IN  = 32,
    parameter int N_OUT = 10,
    parameter int RELU  = 1,
    parameter int WA_W  = $clog2(N_IN * N_OUT),
    parameter int AA_W  = $clog2(N_IN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [AA_W-1:0] act_addr,
    input  logic [15:0]     act_data,
    output logic [WA_W-1:0] w_addr,
    input  logic [15:0]     w_data,
    output logic [5:0]      bias_addr,
    input  logic [15:0]     bias_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_idx,
    output logic [15:0]     out_data,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {IDLE, MAC, BIAS, OUT, DONE} state_t;

    localparam logic [AA_W-1:0] LAST_I = AA_W'(N_IN - 1);
    localparam logic [5:0]      LAST_N = 6'(N_OUT - 1);

    state_t             state;
    state_t             state_next;
    logic [5:0]         neuron;
    logic [AA_W-1:0]    i;
    logic [WA_W-1:0]    w_ptr;
    logic signed [39:0] acc;
    logic [15:0]        out_reg;

    logic signed [31:0] product;
    logic signed [39:0] product_ext;
    logic signed [39:0] bias_ext;
    logic signed [39:0] biased;
    logic signed [39:0] shifted;
    logic [15:0]        result;

    assign product     = $signed(act_data) * $signed(w_data);
    assign product_ext = {{8{product[31]}}, product};
    assign bias_ext    = {{16{bias_data[15]}}, bias_data, 8'h00};
    assign biased      = acc + bias_ext;
    assign shifted     = biased >>> 8;

    // Saturate the Q8.8 view of the accumulator, then optionally clamp negatives.
    always_comb begin
        result = shifted[15:0];
        if (shifted > 40'sd32767) begin
            result = 16'h7FFF;
        end else if (shifted < -40'sd32768) begin
            result = 16'h8000;
        end
        if (RELU != 0 && result[15]) begin
            result = 16'h0000;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = MAC;
            MAC:  if (i == LAST_I) state_next = BIAS;
            BIAS: state_next = OUT;
            OUT: begin
                if (out_ready) begin
                    state_next = (neuron == LAST_N) ? DONE : MAC;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // w_ptr walks neuron*N_IN+i incrementally; it parks on the last weight during BIAS/OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            neuron  <= '0;
            i       <= '0;
            w_ptr   <= '0;
            acc     <= '0;
            out_reg <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        neuron <= '0;
                        i      <= '0;
                        w_ptr  <= '0;
                        acc    <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + product_ext;
                    if (i != LAST_I) begin
                        i     <= i + AA_W'(1);
                        w_ptr <= w_ptr + WA_W'(1);
                    end
                end
                BIAS: begin
                    acc     <= biased;
                    out_reg <= result;
                end
                OUT: begin
                    if (out_ready && neuron != LAST_N) begin
                        neuron <= neuron + 6'd1;
                        i      <= '0;
                        w_ptr  <= w_ptr + WA_W'(1);
                        acc    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign act_addr  = i;
    assign w_addr    = w_ptr;
    assign bias_addr = neuron;
    assign out_idx   = neuron;
    assign out_data  = out_reg;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_layer3_neuron_mac.sv
// tb/tb_layer3_neuron_mac.sv - scoreboard bench for layer3_neuron_mac, ReLU on and off side by side
module tb_layer3_neuron_mac;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int WA_W  = $clog2(N_IN * N_OUT);
    localparam int AA_W  = $clog2(N_IN);

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic ready;

    logic [AA_W-1:0] act_addr [2];
    logic [WA_W-1:0] w_addr [2];
    logic [5:0]      bias_addr [2];
    logic [15:0]     act_data [2];
    logic [15:0]     w_data [2];
    logic [15:0]     bias_data [2];
    logic            out_valid [2];
    logic [5:0]      out_idx [2];
    logic [15:0]     out_data [2];
    logic            busy [2];
    logic            done [2];

    logic [15:0] act_mem [N_IN];
    logic [15:0] w_mem [N_IN*N_OUT];
    logic [15:0] bias_mem [64];

    logic [21:0] q0[$];
    logic [21:0] q1[$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0 has ReLU disabled, instance 1 enabled; both see identical stimulus.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        layer3_neuron_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .RELU(g), .WA_W(WA_W), .AA_W(AA_W)) dut (
            .clk(clk), .reset(reset), .start(start),
            .act_addr(act_addr[g]), .act_data(act_data[g]),
            .w_addr(w_addr[g]), .w_data(w_data[g]),
            .bias_addr(bias_addr[g]), .bias_data(bias_data[g]),
            .out_valid(out_valid[g]), .out_ready(ready),
            .out_idx(out_idx[g]), .out_data(out_data[g]),
            .busy(busy[g]), .done(done[g])
        );
        assign act_data[g]  = act_mem[act_addr[g]];
        assign w_data[g]    = w_mem[w_addr[g]];
        assign bias_data[g] = bias_mem[bias_addr[g]];
    end

    task automatic chk(input string name, input int g, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h expected=%0h at %0t", name, g, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input int n, input int relu);
        longint s = 0;
        for (int k = 0; k < N_IN; k++)
            s += longint'($signed(act_mem[k])) * longint'($signed(w_mem[n*N_IN+k]));
        s += longint'($signed(bias_mem[n])) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu != 0 && s < 0) s = 0;
        return s[15:0];
    endfunction

    task automatic check_reset_values();
        for (int g = 0; g < 2; g++) begin
            chk("rst_out_valid", g, out_valid[g], 0);
            chk("rst_out_idx", g, out_idx[g], 0);
            chk("rst_out_data", g, out_data[g], 0);
            chk("rst_busy", g, busy[g], 0);
            chk("rst_done", g, done[g], 0);
            chk("rst_act_addr", g, act_addr[g], 0);
            chk("rst_w_addr", g, w_addr[g], 0);
            chk("rst_bias_addr", g, bias_addr[g], 0);
        end
    endtask

    task automatic fill_const(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
        for (int k = 0; k < N_IN; k++) act_mem[k] = a;
        for (int k = 0; k < N_IN*N_OUT; k++) w_mem[k] = w;
        for (int k = 0; k < 64; k++) bias_mem[k] = b;
    endtask

    // kind 0: full-range random, 1: small magnitudes, 2: zero activations (bias only)
    task automatic fill_rand(input int kind);
        int t;
        for (int k = 0; k < N_IN; k++) begin
            t = $urandom_range(0, 2047);
            act_mem[k] = (kind == 0) ? 16'($urandom) : (kind == 1) ? 16'(t - 1024) : 16'h0000;
        end
        for (int k = 0; k < N_IN*N_OUT; k++) begin
            t = $urandom_range(0, 2047);
            w_mem[k] = (kind == 1) ? 16'(t - 1024) : 16'($urandom);
        end
        for (int k = 0; k < 64; k++) bias_mem[k] = 16'($urandom);
    endtask

    // Scoreboard monitor: pops on every accepted result, checks hold stability under backpressure.
    initial begin
        bit pend [2];
        logic [15:0] hold_d [2];
        logic [5:0]  hold_i [2];
        logic [21:0] e;
        bit have;
        pend[0] = 0; pend[1] = 0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!reset && out_valid[g]) begin
                    if (pend[g]) begin
                        chk("hold_data", g, out_data[g], hold_d[g]);
                        chk("hold_idx", g, out_idx[g], hold_i[g]);
                    end
                    if (ready) begin
                        have = 0;
                        e = '0;
                        if (g == 0 && q0.size() > 0) begin have = 1; e = q0.pop_front(); end
                        if (g == 1 && q1.size() > 0) begin have = 1; e = q1.pop_front(); end
                        if (have) begin
                            chk("out_idx", g, out_idx[g], e[21:16]);
                            chk("out_data", g, out_data[g], e[15:0]);
                        end else begin
                            chk("unexpected_result", g, 1, 0);
                        end
                        pend[g] = 0;
                    end else begin
                        pend[g] = 1;
                        hold_d[g] = out_data[g];
                        hold_i[g] = out_idx[g];
                    end
                end else begin
                    pend[g] = 0;
                end
            end
        end
    end

    // rmode 0: ready=1, 1: random ready, 2: stall 5 cycles per result
    task automatic run(input int rmode, input int glitch, input int abort);
        int k, first_v, stalls, nn, p, ocnt;
        bit fin;
        for (int n = 0; n < N_OUT; n++) begin
            q0.push_back({6'(n), model(n, 0)});
            q1.push_back({6'(n), model(n, 1)});
        end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; first_v = -1; stalls = 0; nn = 0; p = 0; ocnt = 0; fin = 0;
        while (!fin && k < 400) begin
            if (rmode == 0) ready = 1'b1;
            else if (rmode == 1) ready = 1'($urandom_range(0, 1));
            else ready = !out_valid[0] || (ocnt >= 5);
            if (done[0]) begin
                fin = 1;
                for (int g = 0; g < 2; g++) chk("done_cycle", g, k, N_OUT*(N_IN+2) + stalls);
            end else if (out_valid[0]) begin
                if (first_v < 0) begin
                    first_v = k;
                    chk("first_valid_cycle", 0, first_v, N_IN + 1);
                end
                if (ready) begin nn++; p = 0; ocnt = 0; end
                else begin stalls++; ocnt++; end
            end else begin
                for (int g = 0; g < 2; g++) begin
                    chk("busy", g, busy[g], 1);
                    if (p < N_IN) begin
                        chk("act_addr", g, act_addr[g], p);
                        chk("w_addr", g, w_addr[g], nn*N_IN + p);
                    end else begin
                        chk("bias_addr", g, bias_addr[g], nn);
                    end
                end
                p++;
            end
            start = (glitch != 0 && k == 2);
            if (abort != 0 && nn == 1 && p == 2) begin
                chk("pending_before_reset", 0, q0.size(), 1);
                chk("pending_before_reset", 1, q1.size(), 1);
                reset = 1'b1;
                @(posedge clk); #1;
                check_reset_values();
                reset = 1'b0;
                q0.delete();
                q1.delete();
                return;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        if (!fin) chk("done_timeout", 0, 1, 0);
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            chk("done_one_cycle", g, done[g], 0);
            chk("idle_after_done", g, busy[g], 0);
        end
        chk("queue_drained", 0, q0.size(), 0);
        chk("queue_drained", 1, q1.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        fill_const(16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;

        fill_const(16'h0100, 16'h0100, 16'h0000);
        run(0, 0, 0);
        fill_const(16'h0100, 16'hFF00, 16'h0080);
        run(0, 0, 0);
        fill_const(16'h7FFF, 16'h7FFF, 16'h7FFF);
        run(1, 0, 0);
        fill_const(16'h7FFF, 16'h8001, 16'h7FFF);
        run(0, 0, 0);
        fill_rand(2);
        run(2, 0, 0);
        fill_rand(1);
        run(0, 1, 0);
        fill_rand(1);
        run(0, 0, 1);
        run(0, 0, 0);
        for (int r = 0; r < 8; r++) begin
            fill_rand(r % 3);
            run(1, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer3_neuron_mac.md
# layer3_neuron_mac

Sequential multiply-accumulate engine for the third fully-connected layer of the handwriting MLP. For each output neuron it walks the previous layer's activation buffer and the layer-3 weight ROM, one product per cycle. It then adds that neuron's bias from the 6-bit-addressed, 16-bit, combinationally read layer-3 bias ROM, and applies optional ReLU with saturation. Each result is handed downstream (argmax/classifier) over a valid/ready handshake.

## Interface
- N_IN, 32: inputs per neuron (activations from layer 2).
- N_OUT, 10: neurons in layer 3; must be ≤ 64 (bias ROM depth).
- RELU, 1: 1 = clamp negative results to 0; 0 = pass signed result.
- WA_W, clog2(N_IN*N_OUT): weight address width.
- AA_W, clog2(N_IN): activation address width.
- clk  in  1  single clock; everything on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a full layer pass; sampled only in IDLE.
- act_addr  out  AA_W  activation buffer read address.
- act_data  in  16  activation, signed Q8.8, combinational w.r.t. act_addr.
- w_addr  out  WA_W  weight ROM address = neuron*N_IN + i.
- w_data  in  16  weight, signed Q8.8, combinational.
- bias_addr  out  6  bias ROM address = neuron index.
- bias_data  in  16  bias, signed Q8.8, combinational.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_idx  out  6  neuron index of result.
- out_data  out  16  result, signed Q8.8.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after last result accepted.

## Operation
- States: IDLE, MAC, BIAS, OUT, DONE.
- IDLE: start=1 → MAC, neuron=0, i=0, acc=0. Else stay.
- MAC: acc += sext(act_data*w_data) (32-bit Q16.16 product into 40-bit signed acc). i++ each cycle; when i==N_IN-1 → BIAS.
- BIAS: bias_addr=neuron; acc += sext(bias_data)<<8. Go to OUT.
- OUT: out_data = sat16(acc>>>8) (arithmetic shift, truncation toward −∞). Then ReLU if RELU=1. sat16 clamps to 0x7FFF / 0x8000. Result registered on BIAS→OUT; out_idx=neuron. out_valid=1, held stable until out_valid&&out_ready.
  - On accept: if neuron==N_OUT-1 → DONE; else neuron++, i=0, acc=0, → MAC.
- DONE: done=1 for one cycle → IDLE.
- Addresses driven from registered neuron/i. act_addr=i, w_addr=neuron*N_IN+i (counter-based, no multiplier required). Address outputs are don't-care outside MAC/BIAS but must be stable.
- start outside IDLE ignored; out_ready outside OUT ignored.
- Reset (any state, including mid-MAC or OUT): next edge → IDLE. Clears neuron, i, acc, out_data. No partial result or done emitted.

## Timing
- Reset values: out_valid=0, out_idx=0, out_data=0, busy=0, done=0, act_addr=0, w_addr=0, bias_addr=0.
- start sampled at edge 0 → MAC cycles 1..N_IN → BIAS cycle N_IN+1 → out_valid high from cycle N_IN+2.
- Per neuron with out_ready held 1: N_IN+2 cycles. Full layer: N_OUT*(N_IN+2) cycles, then done pulses the cycle after final accept.
- Backpressure: each cycle out_ready=0 in OUT adds one cycle. out_data/out_idx must not change.
- Accumulator cannot overflow for N_IN ≤ 256 (40-bit). Saturation only at output.

## Test plan
- N_IN=4, N_OUT=2, all act=0x0100, w=0x0100, bias=0x0000 → out_idx 0 then 1, out_data 0x0400 each. First out_valid at cycle 6. done at cycle 13 with out_ready=1.
- acts 0x0100, weights 0xFF00 (−1.0), bias 0x0080 → pre-ReLU −3.5. RELU=1 gives 0x0000; RELU=0 gives 0xFC80.
- acts 0x7FFF, weights 0x7FFF, bias 0x7FFF → out_data 0x7FFF (saturated). Negated weights with RELU=0 → 0x8000.
- Hold out_ready=0 for 5 cycles in OUT → out_valid, out_data, out_idx stable. MAC of next neuron begins the cycle after accept.
- Pulse start during MAC → ignored, result sequence unchanged. Assert reset in MAC of neuron 1 → IDLE next cycle, all outputs at reset values. Fresh start → results restart at out_idx 0.
- Bias-only check: acts 0 → out_data equals each bias_data. Relation to RELU as above. bias_addr equals neuron index during BIAS.
